csa5_accum_ctrl: RTL and testbench

CSA5_ACCUM_CTRL -- requirements
Module: csa5_accum_ctrl

---
 rtl/csa5_accum_ctrl_pkg.sv | 22 ++
 rtl/csa5_accum_ctrl_row.sv | 80 ++++++++
 rtl/csa5_accum_ctrl.sv | 162 ++++++++++++++++
 tb/tb_csa5_accum_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csa5_accum_ctrl_pkg.sv
// Shared types and constants for the carry-save five-operand accumulator.
package csa5_accum_ctrl_pkg;

  // Default operand width in bits.
  localparam int DEF_W = 8;

  // Width of the saturating operand counter.
  localparam int CNT_W = 8;

  // Controller states: collect beats, resolve carries, hold the result.
  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Number of operands flagged present in a three-bit mask.
  function automatic logic [1:0] popcount3(input logic [2:0] mask);
    return {1'b0, mask[0]} + {1'b0, mask[1]} + {1'b0, mask[2]};
  endfunction

endpackage

// File: rtl/csa5_accum_ctrl_row.sv
// Bit-sliced 5:2 compressor row.
// Each slice compresses three operand bits plus the stored sum/carry bits.
// co1/co2 depend only on the slice's own inputs, so the row has no ripple path.

// One 5:2 compressor slice built from three chained full adders.
module compressor_5to2 (
  input  logic a0,
  input  logic a1,
  input  logic a2,
  input  logic a3,
  input  logic a4,
  input  logic ci1,
  input  logic ci2,
  output logic co1,
  output logic co2,
  output logic sum,
  output logic carry
);
  logic s1_s;
  logic s2_s;

  // Three full adders: a0+a1+a2+a3+a4+ci1+ci2 = sum + 2*(carry+co1+co2).
  always_comb begin
    s1_s  = a0 ^ a1 ^ a2;
    co1   = (a0 & a1) | (a0 & a2) | (a1 & a2);
    s2_s  = s1_s ^ a3 ^ a4;
    co2   = (s1_s & a3) | (s1_s & a4) | (a3 & a4);
    sum   = s2_s ^ ci1 ^ ci2;
    carry = (s2_s & ci1) | (s2_s & ci2) | (ci1 & ci2);
  end
endmodule

// Full row of ACC_W compressor slices plus the carry realignment.
module csa5_row #(
  parameter int ACC_W = 16
) (
  input  logic [ACC_W-1:0] op0,
  input  logic [ACC_W-1:0] op1,
  input  logic [ACC_W-1:0] op2,
  input  logic [ACC_W-1:0] s_cur,
  input  logic [ACC_W-1:0] c_cur,
  output logic [ACC_W-1:0] s_nxt,
  output logic [ACC_W-1:0] c_nxt
);
  logic [ACC_W-1:0] co1_s;
  logic [ACC_W-1:0] co2_s;
  logic [ACC_W-1:0] ci1_s;
  logic [ACC_W-1:0] ci2_s;
  logic [ACC_W-1:0] carry_s;
  logic             msb_unused_s;

  // Slice i takes its lateral carries from slice i-1; slice 0 takes zero.
  always_comb begin
    ci1_s = {co1_s[ACC_W-2:0], 1'b0};
    ci2_s = {co2_s[ACC_W-2:0], 1'b0};
  end

  genvar i;
  for (i = 0; i < ACC_W; i++) begin : g_slice
    compressor_5to2 u_cmp (
      .a0    (op0[i]),
      .a1    (op1[i]),
      .a2    (op2[i]),
      .a3    (s_cur[i]),
      .a4    (c_cur[i]),
      .ci1   (ci1_s[i]),
      .ci2   (ci2_s[i]),
      .co1   (co1_s[i]),
      .co2   (co2_s[i]),
      .sum   (s_nxt[i]),
      .carry (carry_s[i])
    );
  end

  // Carries weigh one position higher; anything leaving the MSB wraps away.
  always_comb begin
    c_nxt        = {carry_s[ACC_W-2:0], 1'b0};
    msb_unused_s = co1_s[ACC_W-1] ^ co2_s[ACC_W-1] ^ carry_s[ACC_W-1];
  end
endmodule

// File: rtl/csa5_accum_ctrl.sv
// Carry-save accumulator of up to three operands per beat.
// Beats are folded into redundant S/C state; the last beat triggers a
// single carry-propagate add whose result is held until consumed.
module csa5_accum_ctrl
  import csa5_accum_ctrl_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = W + 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*W-1:0]     in_data,
  input  logic [2:0]         in_mask,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf
);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [ACC_W-1:0]   s_r;
  logic [ACC_W-1:0]   c_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ovf_r;
  logic [ACC_W-1:0]   out_sum_r;
  logic [CNT_W-1:0]   out_count_r;
  logic               out_ovf_r;

  logic               xfer_s;
  logic [ACC_W-1:0]   op0_s;
  logic [ACC_W-1:0]   op1_s;
  logic [ACC_W-1:0]   op2_s;
  logic [ACC_W-1:0]   row_s_s;
  logic [ACC_W-1:0]   row_c_s;
  logic [CNT_W:0]     cnt_sum_s;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               cnt_of_s;

  // Handshake and output decode from the registered state.
  always_comb begin
    in_ready  = (state_r == ACCUM);
    out_valid = (state_r == HOLD);
    xfer_s    = in_valid && (state_r == ACCUM);
    out_sum   = out_sum_r;
    out_count = out_count_r;
    out_ovf   = out_ovf_r;
  end

  // Zero-extend each operand, forcing absent operands to zero.
  always_comb begin
    op0_s = in_mask[0] ? ACC_W'(in_data[W-1:0])     : {ACC_W{1'b0}};
    op1_s = in_mask[1] ? ACC_W'(in_data[2*W-1:W])   : {ACC_W{1'b0}};
    op2_s = in_mask[2] ? ACC_W'(in_data[3*W-1:2*W]) : {ACC_W{1'b0}};
  end

  csa5_row #(
    .ACC_W (ACC_W)
  ) u_row (
    .op0   (op0_s),
    .op1   (op1_s),
    .op2   (op2_s),
    .s_cur (s_r),
    .c_cur (c_r),
    .s_nxt (row_s_s),
    .c_nxt (row_c_s)
  );

  // Saturating operand count; the extra top bit flags passing the ceiling.
  always_comb begin
    cnt_sum_s = {1'b0, cnt_r} + {{(CNT_W-1){1'b0}}, popcount3(in_mask)};
    cnt_of_s  = cnt_sum_s[CNT_W];
    if (cnt_of_s) begin
      cnt_nxt_s = {CNT_W{1'b1}};
    end else begin
      cnt_nxt_s = cnt_sum_s[CNT_W-1:0];
    end
  end

  // Next-state logic for the three-state controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ACCUM: begin
        if (xfer_s && in_last) begin
          state_nxt_s = RESOLVE;
        end else begin
          state_nxt_s = ACCUM;
        end
      end
      RESOLVE: state_nxt_s = HOLD;
      HOLD: begin
        if (out_ready) begin
          state_nxt_s = ACCUM;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: state_nxt_s = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Accumulator, counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r         <= {ACC_W{1'b0}};
      c_r         <= {ACC_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      ovf_r       <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      out_count_r <= {CNT_W{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (xfer_s) begin
            // An empty beat must not recompress S/C, so it leaves them alone.
            if (in_mask != 3'b000) begin
              s_r <= row_s_s;
              c_r <= row_c_s;
            end
            cnt_r <= cnt_nxt_s;
            ovf_r <= ovf_r | cnt_of_s;
          end
        end
        RESOLVE: begin
          out_sum_r   <= s_r + c_r;
          out_count_r <= cnt_r;
          out_ovf_r   <= ovf_r;
        end
        HOLD: begin
          if (out_ready) begin
            s_r   <= {ACC_W{1'b0}};
            c_r   <= {ACC_W{1'b0}};
            cnt_r <= {CNT_W{1'b0}};
            ovf_r <= 1'b0;
          end
        end
        default: begin
          s_r   <= {ACC_W{1'b0}};
          c_r   <= {ACC_W{1'b0}};
          cnt_r <= {CNT_W{1'b0}};
          ovf_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa5_accum_ctrl.sv
// Self-checking bench for csa5_accum_ctrl with W=8, ACC_W=16.
module tb_csa5_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [2:0]  in_mask;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  csa5_accum_ctrl #(.W(8), .ACC_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until accepted (bounded); returns after the accepting edge.
  task automatic send_beat(input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0,
                           input logic [2:0] mk, input logic lst);
    int n;
    in_valid = 1'b1;
    in_data  = {d2, d1, d0};
    in_mask  = mk;
    in_last  = lst;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 24'hA5A5A5;
    in_mask  = 3'b111;
    in_last  = 1'b1;
  endtask

  // Wait (bounded) for out_valid; reports a timeout as a failed comparison.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  // Consume the held result with a single out_ready pulse.
  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [15:0] m_sum;
  int          m_cnt;
  int          nb;
  int          gap;
  logic [23:0] rd;
  logic [2:0]  rm;
  logic [15:0] held_sum;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 24'h000000;
    in_mask   = 3'b000;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_out_ovf",   32'(out_ovf),   32'd0);

    // Single beat {3,2,1}: RESOLVE after acceptance, HOLD one edge later
    send_beat(8'd3, 8'd2, 8'd1, 3'b111, 1'b1);
    chk("single_resolve_valid", 32'(out_valid), 32'd0);
    chk("single_resolve_ready", 32'(in_ready),  32'd0);
    tick();
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_sum",   32'(out_sum),   32'd6);
    chk("single_count", 32'(out_count), 32'd3);
    chk("single_ovf",   32'(out_ovf),   32'd0);
    out_ready = 1'b1;
    #1;
    chk("single_no_same_cycle_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    chk("single_after_ready", 32'(in_ready),  32'd1);
    chk("single_after_valid", 32'(out_valid), 32'd0);

    // Multi-beat with masking, then backpressure
    send_beat(8'd255, 8'd255, 8'd255, 3'b111, 1'b0);
    tick();  // idle cycle with junk on the bus, must be ignored
    send_beat(8'd255, 8'd255, 8'd255, 3'b011, 1'b0);
    send_beat(8'd7, 8'd9, 8'd9, 3'b001, 1'b1);
    tick();
    chk("multi_valid", 32'(out_valid), 32'd1);
    chk("multi_sum",   32'(out_sum),   32'd1284);
    chk("multi_count", 32'(out_count), 32'd6);
    chk("multi_ovf",   32'(out_ovf),   32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_sum",      32'(out_sum),   32'd1284);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
    end
    consume();
    chk("bp_release_ready", 32'(in_ready), 32'd1);

    // Empty beat keeps state, then one op2 beat: state was cleared
    send_beat(8'd1, 8'd2, 8'd3, 3'b000, 1'b0);
    send_beat(8'd4, 8'd0, 8'd0, 3'b100, 1'b1);
    wait_valid();
    chk("empty_sum",   32'(out_sum),   32'd4);
    chk("empty_count", 32'(out_count), 32'd1);
    chk("empty_ovf",   32'(out_ovf),   32'd0);
    consume();

    // Empty last beat closes an empty set
    send_beat(8'd9, 8'd9, 8'd9, 3'b000, 1'b1);
    wait_valid();
    chk("emptyset_sum",   32'(out_sum),   32'd0);
    chk("emptyset_count", 32'(out_count), 32'd0);
    consume();

    // Saturation: 86 full beats = 258 operands
    for (int i = 0; i < 86; i++) begin
      send_beat(8'd255, 8'd255, 8'd255, 3'b111, (i == 85) ? 1'b1 : 1'b0);
    end
    wait_valid();
    chk("sat_count", 32'(out_count), 32'd255);
    chk("sat_ovf",   32'(out_ovf),   32'd1);
    chk("sat_sum",   32'(out_sum),   32'd254);
    consume();

    // Mid-operation reset while in RESOLVE
    send_beat(8'd0, 8'd0, 8'd7, 3'b111, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid",   32'(out_valid), 32'd0);
    chk("midrst_ready",   32'(in_ready),  32'd1);
    chk("midrst_out_sum", 32'(out_sum),   32'd0);
    tick();
    chk("midrst_valid2", 32'(out_valid), 32'd0);
    send_beat(8'd0, 8'd0, 8'd5, 3'b001, 1'b1);
    wait_valid();
    chk("midrst_sum",   32'(out_sum),   32'd5);
    chk("midrst_count", 32'(out_count), 32'd1);
    chk("midrst_ovf",   32'(out_ovf),   32'd0);
    consume();

    // Reset while holding an unconsumed result
    send_beat(8'd1, 8'd1, 8'd1, 3'b111, 1'b1);
    wait_valid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("holdrst_valid", 32'(out_valid), 32'd0);
    chk("holdrst_count", 32'(out_count), 32'd0);

    // Randomised sets against a reference sum, with input and output gaps
    for (int s = 0; s < 300; s++) begin
      m_sum = 16'd0;
      m_cnt = 0;
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          in_data = 24'($urandom);
          in_mask = 3'($urandom);
          tick();
        end
        rd = 24'($urandom);
        rm = 3'($urandom);
        send_beat(rd[23:16], rd[15:8], rd[7:0], rm, (b == nb - 1) ? 1'b1 : 1'b0);
        for (int k = 0; k < 3; k++) begin
          if (rm[k]) begin
            m_sum = m_sum + 16'(rd[8*k +: 8]);
            m_cnt = m_cnt + 1;
          end
        end
      end
      wait_valid();
      chk("rnd_sum",   32'(out_sum),   32'(m_sum));
      chk("rnd_count", 32'(out_count), 32'(m_cnt));
      chk("rnd_ovf",   32'(out_ovf),   32'd0);
      held_sum = out_sum;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        tick();
      end
      chk("rnd_hold_sum", 32'(out_sum), 32'(held_sum));
      consume();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
